serial_cmp_ctrl: RTL and testbench
==================================

Name: serial_cmp_ctrl

Overview:
Sequencer that drives an external 1-bit comparator (inputs x, y; flags eq, gt) bit-serially to compare two WIDTH-bit unsigned operands.
- Operand order: MSB-first, one bit per clock.
- Early exit: optional stop on the first differing bit.
- Handshakes: valid/ready on the start side and on the result side.
- Placement: sits between a requesting master and the shared 1-bit comparator cell, and is the only driver of that cell's inputs.

Parameters:
WIDTH, 8, operand width in bits; legal range WIDTH >= 2.
EARLY_EXIT, 1, 1 = stop at first differing bit; 0 = always walk all WIDTH bits, with the first difference kept sticky.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start_valid  in  1  master presents operands.
start_ready  out  1  controller idle; a/b accepted when start_valid & start_ready.
a  in  WIDTH  operand A, sampled only at start handshake.
b  in  WIDTH  operand B, sampled only at start handshake.
res_valid  out  1  result available.
res_ready  in  1  master consumes result.
res_eq  out  1  A == B.
res_gt  out  1  A > B.
res_lt  out  1  A < B.
busy  out  1  high while in SHIFT.
cmp_x  out  1  bit of A driven to comparator.
cmp_y  out  1  bit of B driven to comparator.
cmp_eq  in  1  comparator equal flag (combinational from cmp_x/cmp_y).
cmp_gt  in  1  comparator x>y flag.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; shift registers and bit counter cleared.
  - res_valid=0, res_eq=res_gt=res_lt=0, busy=0, cmp_x=cmp_y=0.
  - start_ready=1 in IDLE, including while reset is held.
- Comparator timing: comparator is combinational; the controller samples cmp_eq/cmp_gt in the same cycle it drives cmp_x/cmp_y.
- Bit decode rules:
  - cmp_eq has priority: cmp_eq=1 means equal regardless of cmp_gt.
  - lt is derived as !cmp_eq & !cmp_gt.
- States: IDLE, SHIFT, DONE. Encodings come from the shared header.
- IDLE:
  - start_ready=1.
  - On handshake: load sa<=a, sb<=b, cnt<=WIDTH-1, clear sticky diff flags, go to SHIFT.
- SHIFT:
  - start_ready=0, busy=1.
  - cmp_x=sa[WIDTH-1], cmp_y=sb[WIDTH-1]; outside SHIFT both are driven 0.
  - Each cycle, sa/sb shift left by 1 and cnt decrements.
  - First cycle with cmp_eq=0 captures gt/lt into sticky flags. Later differences never overwrite them.
  - EARLY_EXIT=1 and cmp_eq=0: go to DONE, with the result taken from the current bit.
  - Otherwise cnt==0: go to DONE, with the result = sticky flag, or eq if no difference was seen.
- DONE:
  - res_valid=1.
  - Exactly one of res_eq/res_gt/res_lt is 1, registered and held stable until the handshake.
  - start_valid is ignored (start_ready=0).
  - On res_ready: next edge returns to IDLE; res_valid and result flags clear to 0.
- Latency, with start handshake at edge T:
  - SHIFT occupies T+1..T+1+p, where p = MSB-first index of the deciding bit.
  - res_valid is high from edge T+p+2.
  - Full walk (equal operands, or EARLY_EXIT=0): res_valid at T+WIDTH+1.
- Throughput:
  - No back-to-back overlap; a new start is accepted no earlier than the cycle after the result handshake.
  - res_ready high on arrival gives a 1-cycle DONE.
- Operand stability: a/b changes after the start handshake have no effect.
- Reset mid-operation: immediate abort in any state; no result is produced after release.
- Counter width: $clog2(WIDTH). Counter wrap is not reachable: SHIFT always exits at cnt==0.

Decomposition:
- Shared header cmp_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - result codes RES_EQ/RES_GT/RES_LT.
- Natural sub-module: bit_cmp, the 1-bit comparator (x, y -> eq, gt).
  - Instantiated beside the controller at top level and in the bench, not inside serial_cmp_ctrl.
- The controller itself is one module: FSM plus shift and counter datapath.

Test Plan:
1. Reset: hold rst_n=0 with start_valid=1 -> start_ready=1, res_valid=0, all result flags 0, cmp_x=cmp_y=0; after release, first handshake accepted normally.
2. Equal operands: WIDTH=8, a=8'hA5, b=8'hA5 -> cmp_x sequence 1,0,1,0,0,1,0,1 over 8 SHIFT cycles; res_eq=1 at T+9.
3. MSB decides, EARLY_EXIT=1: a=8'h80, b=8'h7F -> busy for exactly 1 cycle; res_gt=1 at T+2.
4. Sticky difference, EARLY_EXIT=0: a=8'h01, b=8'h02 -> first difference at bit1 (lt); the bit0 difference (gt) is ignored; res_lt=1 at T+9.
5. Back-pressure: result ready with res_ready=0 for 5 cycles -> res_valid and flags stable, start_ready=0, start_valid pulses ignored; res_ready=1 -> IDLE next cycle, then new start accepted.
6. Reset mid-SHIFT: assert rst_n=0 on the 3rd SHIFT cycle of a=8'h0F, b=8'h0E -> busy and res_valid drop immediately; no res_valid after release.

Source files
------------

// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared encodings for the bit-serial compare sequencer:
// FSM states, one-hot result codes and the bit decode helper.
package serial_cmp_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // {eq, gt, lt}, exactly one bit set for a valid result
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

    // eq wins over gt; lt is whatever is neither
    function automatic logic [2:0] res_code(input logic eq, input logic gt);
        if (eq)
            return RES_EQ;
        else if (gt)
            return RES_GT;
        else
            return RES_LT;
    endfunction

endpackage

// File: rtl/serial_cmp_ctrl_bit_cmp.sv
// Shared 1-bit comparator cell, purely combinational.
// Lives beside the sequencer, never inside it.
module bit_cmp (
    input  logic x,
    input  logic y,
    output logic eq,
    output logic gt
);

    assign eq = (x == y);
    assign gt = x & ~y;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first bit-serial compare sequencer driving an external
// 1-bit comparator, with valid/ready on start and result sides.
module serial_cmp_ctrl
    import serial_cmp_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_eq,
    output logic             res_gt,
    output logic             res_lt,
    output logic             busy,
    output logic             cmp_x,
    output logic             cmp_y,
    input  logic             cmp_eq,
    input  logic             cmp_gt
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic [2:0]       sticky;
    logic [2:0]       res;
    logic [2:0]       bit_res;
    logic             diff;

    assign diff    = ~cmp_eq;
    assign bit_res = res_code(cmp_eq, cmp_gt);

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state == ST_SHIFT);
    assign res_valid   = (state == ST_DONE);
    assign cmp_x       = busy & sa[WIDTH-1];
    assign cmp_y       = busy & sb[WIDTH-1];

    assign {res_eq, res_gt, res_lt} = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            sticky <= RES_NONE;
            res    <= RES_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        sa     <= a;
                        sb     <= b;
                        cnt    <= CW'(WIDTH - 1);
                        sticky <= RES_NONE;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sa <= sa << 1;
                    sb <= sb << 1;
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    // only the first differing bit is remembered
                    if (diff && sticky == RES_NONE)
                        sticky <= bit_res;
                    if (EARLY_EXIT && diff) begin
                        res   <= bit_res;
                        state <= ST_DONE;
                    end else if (cnt == '0) begin
                        res   <= (sticky != RES_NONE) ? sticky : bit_res;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res   <= RES_NONE;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    res   <= RES_NONE;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed bench: one early-exit and one full-walk sequencer,
// each paired with its own comparator cell.
module tb_serial_cmp_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       sv0, sr0, rr0, rv0, eq0, gt0, lt0, busy0, x0, y0, ceq0, cgt0;
    logic       sv1, sr1, rr1, rv1, eq1, gt1, lt1, busy1, x1, y1, ceq1, cgt1;
    logic [7:0] a0, b0, a1, b1;

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv0), .start_ready(sr0), .a(a0), .b(b0),
        .res_valid(rv0), .res_ready(rr0),
        .res_eq(eq0), .res_gt(gt0), .res_lt(lt0), .busy(busy0),
        .cmp_x(x0), .cmp_y(y0), .cmp_eq(ceq0), .cmp_gt(cgt0)
    );
    bit_cmp u_cmp0 (.x(x0), .y(y0), .eq(ceq0), .gt(cgt0));

    serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1),
        .res_valid(rv1), .res_ready(rr1),
        .res_eq(eq1), .res_gt(gt1), .res_lt(lt1), .busy(busy1),
        .cmp_x(x1), .cmp_y(y1), .cmp_eq(ceq1), .cmp_gt(cgt1)
    );
    bit_cmp u_cmp1 (.x(x1), .y(y1), .eq(ceq1), .gt(cgt1));

    // sel picks which instance the run/ack tasks talk to
    logic       sel;
    logic       rv_s, sr_s, busy_s, x_s;
    logic [2:0] fl_s;
    assign rv_s   = sel ? rv1 : rv0;
    assign sr_s   = sel ? sr1 : sr0;
    assign busy_s = sel ? busy1 : busy0;
    assign x_s    = sel ? x1 : x0;
    assign fl_s   = sel ? {eq1, gt1, lt1} : {eq0, gt0, lt0};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output int nb, output logic [7:0] xs);
        @(negedge clk);
        if (sel) begin a1 = av; b1 = bv; sv1 = 1'b1; end
        else     begin a0 = av; b0 = bv; sv0 = 1'b1; end
        check("start_ready", sr_s, 1);
        @(posedge clk); #1;
        sv0 = 1'b0; sv1 = 1'b0;
        // operands wiggle after the handshake and must not matter
        a0 = ~av; b0 = bv ^ 8'h5A; a1 = ~av; b1 = bv ^ 8'h5A;
        lat = 1; nb = 0; xs = '0;
        while (!rv_s && lat < 40) begin
            if (busy_s) begin xs = {xs[6:0], x_s}; nb++; end
            @(posedge clk); #1;
            lat++;
        end
        check("res_arrive", rv_s, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        if (sel) rr1 = 1'b1; else rr0 = 1'b1;
        @(posedge clk); #1;
        rr0 = 1'b0; rr1 = 1'b0;
        check("ack_rv", rv_s, 0);
        check("ack_sr", sr_s, 1);
        check("ack_flags", fl_s, 3'b000);
    endtask

    int         lat, nb, cnt;
    logic [7:0] xs;
    logic [2:0] held;

    initial begin
        sel = 1'b0;
        rst_n = 1'b0;
        sv0 = 1'b1; sv1 = 1'b1; rr0 = 1'b0; rr1 = 1'b0;
        a0 = 8'hFF; b0 = 8'h00; a1 = 8'hFF; b1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sr", sr0, 1);
        check("rst_rv", rv0, 0);
        check("rst_flags", {eq0, gt0, lt0}, 3'b000);
        check("rst_busy", busy0, 0);
        check("rst_xy", {x0, y0}, 2'b00);
        check("rst_sr1", sr1, 1);
        @(negedge clk);
        sv0 = 1'b0; sv1 = 1'b0;
        rst_n = 1'b1;

        run(8'hA5, 8'hA5, lat, nb, xs);
        check("eq_lat", lat, 9);
        check("eq_busy", nb, 8);
        check("eq_xseq", xs, 8'hA5);
        check("eq_flags", fl_s, 3'b100);
        ack();

        run(8'h12, 8'h13, lat, nb, xs);
        check("lsb_lat", lat, 9);
        check("lsb_flags", fl_s, 3'b001);
        ack();

        run(8'h80, 8'h7F, lat, nb, xs);
        check("msb_lat", lat, 2);
        check("msb_busy", nb, 1);
        check("msb_flags", fl_s, 3'b010);
        held = fl_s;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sv0 = i[0]; a0 = 8'h00; b0 = 8'hFF;
            @(posedge clk); #1;
            check("bp_rv", rv0, 1);
            check("bp_flags", {eq0, gt0, lt0}, held);
            check("bp_sr", sr0, 0);
        end
        sv0 = 1'b0;
        ack();
        run(8'h3C, 8'h3C, lat, nb, xs);
        check("after_bp_flags", fl_s, 3'b100);
        ack();

        sel = 1'b1;
        run(8'h01, 8'h02, lat, nb, xs);
        check("sticky_lat", lat, 9);
        check("sticky_busy", nb, 8);
        check("sticky_flags", fl_s, 3'b001);
        ack();
        run(8'h80, 8'h7F, lat, nb, xs);
        check("full_msb_lat", lat, 9);
        check("full_msb_flags", fl_s, 3'b010);
        ack();

        sel = 1'b0;
        @(negedge clk);
        a0 = 8'h0F; b0 = 8'h0E; sv0 = 1'b1;
        @(posedge clk); #1;
        sv0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_rv", rv0, 0);
        check("abort_sr", sr0, 1);
        check("abort_x", x0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rv0 || busy0) cnt++;
        end
        check("no_result", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
